control_sequencer: RTL and testbench

- Hardwired control unit that drives every datapath/memory control strobe of the System block.
- Replaces hand-sequenced stimulus with a fetch/decode/execute FSM keyed on IR[31:27] (Mini SRC opcode set).
- Sits directly upstream of System: consumes IR and con_ff_bit, produces the control word one step per Clock.

---
 rtl/control_sequencer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// Hardwired fetch/decode/execute control unit for the Mini SRC System block.
// A step counter (T0..T7) plus a terminal HALT state walks every instruction
// through a common three-step fetch and an opcode-specific execute sequence.
// The control word is decoded combinationally from the current step and the
// opcode field IR[31:27], so each control strobe is valid for one full Clock
// period.
//
// Ports
//   Clock            in   system clock, rising edge active
//   clear            in   asynchronous active-low reset
//   IR               in   instruction register, opcode = IR[31:27]
//   con_ff_bit       in   branch condition flip-flop
//   HIout..Cout      out  bus drivers (at most one per cycle)
//   MARin..outport_in out register load enables
//   Gra/Grb/Grc      out  register-field select for the select/encode logic
//   Rin/Rout/BAout   out  register-file load / drive / base-address drive
//   opcode           out  ALU operation select
//   IncPC            out  ALU PC+1 mode
//   Mem_Read         out  MDR source select / RAM read
//   Mem_Write        out  RAM write
//   Mem_enable512x32 out  RAM enable
//   run              out  high while not halted and not in reset
// -----------------------------------------------------------------------------
module control_sequencer #(
  parameter int         DATA_WIDTH = 32,
  parameter logic [4:0] OP_ADD     = 5'b00011
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] IR,
  input  logic                  con_ff_bit,
  // bus drivers
  output logic                  HIout,
  output logic                  LOout,
  output logic                  Zhi_out,
  output logic                  Zlo_out,
  output logic                  PCout,
  output logic                  MDRout,
  output logic                  Inport_out,
  output logic                  Cout,
  // register loads
  output logic                  MARin,
  output logic                  Zin,
  output logic                  PCin,
  output logic                  MDRin,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  HIin,
  output logic                  LOin,
  output logic                  CONin,
  output logic                  outport_in,
  // register select / encode
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  // ALU
  output logic [4:0]            opcode,
  output logic                  IncPC,
  // memory
  output logic                  Mem_Read,
  output logic                  Mem_Write,
  output logic                  Mem_enable512x32,
  // status
  output logic                  run
);

  // Opcodes that get individual treatment; ranges are handled in the decode.
  localparam logic [4:0] OPC_LD   = 5'b00000;
  localparam logic [4:0] OPC_LDI  = 5'b00001;
  localparam logic [4:0] OPC_ST   = 5'b00010;
  localparam logic [4:0] OPC_DIV  = 5'b01111;
  localparam logic [4:0] OPC_MUL  = 5'b10000;
  localparam logic [4:0] OPC_NEG  = 5'b10001;
  localparam logic [4:0] OPC_NOT  = 5'b10010;
  localparam logic [4:0] OPC_BR   = 5'b10011;
  localparam logic [4:0] OPC_JR   = 5'b10100;
  localparam logic [4:0] OPC_JAL  = 5'b10101;
  localparam logic [4:0] OPC_IN   = 5'b10110;
  localparam logic [4:0] OPC_OUT  = 5'b10111;
  localparam logic [4:0] OPC_MFHI = 5'b11000;
  localparam logic [4:0] OPC_MFLO = 5'b11001;
  localparam logic [4:0] OPC_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ST_T0   = 4'd0,
    ST_T1   = 4'd1,
    ST_T2   = 4'd2,
    ST_T3   = 4'd3,
    ST_T4   = 4'd4,
    ST_T5   = 4'd5,
    ST_T6   = 4'd6,
    ST_T7   = 4'd7,
    ST_HALT = 4'd8
  } state_t;

  state_t     state_r;
  state_t     last_s;
  logic [4:0] op_s;
  logic       unused_ir_s;

  assign op_s        = IR[DATA_WIDTH-1 -: 5];
  // Operand fields are consumed by the datapath, not by the sequencer.
  assign unused_ir_s = ^IR[DATA_WIDTH-6:0];

  // Final execute step of each opcode; after it the counter wraps to T0.
  // Undefined opcodes, nop and halt all end at T3.
  function automatic state_t last_step(input logic [4:0] op);
    state_t s;
    case (op) inside
      [5'd3:5'd14]:              s = ST_T5;  // 3-register ALU and immediates
      OPC_LDI:                   s = ST_T5;
      OPC_LD, OPC_ST:            s = ST_T7;
      OPC_DIV, OPC_MUL, OPC_BR:  s = ST_T6;
      OPC_NEG, OPC_NOT, OPC_JAL: s = ST_T4;
      default:                   s = ST_T3;
    endcase
    return s;
  endfunction

  assign last_s = last_step(op_s);

  // Step counter: advance one step per Clock, wrap after the last execute
  // step, never count past T7, and park in HALT until reset.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_r <= ST_T0;
    end else begin
      case (state_r)
        ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
          if ((state_r == ST_T3) && (op_s == OPC_HALT)) begin
            state_r <= ST_HALT;
          end else if ((state_r == last_s) || (state_r == ST_T7)) begin
            state_r <= ST_T0;
          end else begin
            state_r <= state_t'(state_r + 4'd1);
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_T0;  // unreachable encodings recover to fetch
      endcase
    end
  end

  // Control word decode from step and opcode; everything is forced low while
  // clear is asserted so reset acts on the outputs without waiting for Clock.
  always_comb begin
    HIout            = 1'b0;
    LOout            = 1'b0;
    Zhi_out          = 1'b0;
    Zlo_out          = 1'b0;
    PCout            = 1'b0;
    MDRout           = 1'b0;
    Inport_out       = 1'b0;
    Cout             = 1'b0;
    MARin            = 1'b0;
    Zin              = 1'b0;
    PCin             = 1'b0;
    MDRin            = 1'b0;
    IRin             = 1'b0;
    Yin              = 1'b0;
    HIin             = 1'b0;
    LOin             = 1'b0;
    CONin            = 1'b0;
    outport_in       = 1'b0;
    Gra              = 1'b0;
    Grb              = 1'b0;
    Grc              = 1'b0;
    Rin              = 1'b0;
    Rout             = 1'b0;
    BAout            = 1'b0;
    opcode           = 5'b00000;
    IncPC            = 1'b0;
    Mem_Read         = 1'b0;
    Mem_Write        = 1'b0;
    Mem_enable512x32 = 1'b0;
    run              = 1'b0;

    if (clear) begin
      run = (state_r != ST_HALT);
      case (state_r)
        ST_T0: begin
          PCout = 1'b1; IncPC = 1'b1; MARin = 1'b1; Zin = 1'b1;
        end
        ST_T1: begin
          Zlo_out = 1'b1; PCin = 1'b1; MDRin = 1'b1;
          Mem_Read = 1'b1; Mem_enable512x32 = 1'b1;
        end
        ST_T2: begin
          MDRout = 1'b1; IRin = 1'b1;
        end
        ST_T3: begin
          case (op_s) inside
            [5'd3:5'd14]: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OPC_NEG, OPC_NOT: begin
              Grb = 1'b1; Rout = 1'b1; opcode = op_s; Zin = 1'b1;
            end
            OPC_DIV, OPC_MUL: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            OPC_LD, OPC_LDI, OPC_ST: begin
              Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
            end
            OPC_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            OPC_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            // PC was already incremented during fetch, so it is the link value.
            OPC_JAL:  begin Grb = 1'b1; Rin = 1'b1; PCout = 1'b1; end
            OPC_IN:   begin Gra = 1'b1; Rin = 1'b1; Inport_out = 1'b1; end
            OPC_OUT:  begin Gra = 1'b1; Rout = 1'b1; outport_in = 1'b1; end
            OPC_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OPC_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default:  begin end  // nop, halt, undefined: empty step
          endcase
        end
        ST_T4: begin
          case (op_s) inside
            [5'd3:5'd11]: begin
              Grc = 1'b1; Rout = 1'b1; opcode = op_s; Zin = 1'b1;
            end
            [5'd12:5'd14]: begin Cout = 1'b1; opcode = op_s; Zin = 1'b1; end
            OPC_NEG, OPC_NOT: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OPC_DIV, OPC_MUL: begin
              Grb = 1'b1; Rout = 1'b1; opcode = op_s; Zin = 1'b1;
            end
            OPC_LD, OPC_LDI, OPC_ST: begin
              Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1;
            end
            OPC_BR:  begin PCout = 1'b1; Yin = 1'b1; end
            OPC_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            default: begin end
          endcase
        end
        ST_T5: begin
          case (op_s) inside
            [5'd3:5'd14], OPC_LDI: begin
              Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
            end
            OPC_DIV, OPC_MUL: begin Zlo_out = 1'b1; LOin = 1'b1; end
            OPC_LD, OPC_ST:   begin Zlo_out = 1'b1; MARin = 1'b1; end
            OPC_BR: begin Cout = 1'b1; opcode = OP_ADD; Zin = 1'b1; end
            default: begin end
          endcase
        end
        ST_T6: begin
          case (op_s)
            OPC_DIV, OPC_MUL: begin Zhi_out = 1'b1; HIin = 1'b1; end
            OPC_LD: begin
              Mem_Read = 1'b1; Mem_enable512x32 = 1'b1; MDRin = 1'b1;
            end
            // Mem_Read stays low so MDR loads from the bus rather than RAM.
            OPC_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            // Branch always spends this cycle; the PC only loads when taken.
            OPC_BR: begin
              if (con_ff_bit) begin
                Zlo_out = 1'b1; PCin = 1'b1;
              end else begin
                PCin = 1'b0;
              end
            end
            default: begin end
          endcase
        end
        ST_T7: begin
          case (op_s)
            OPC_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            OPC_ST:  begin Mem_Write = 1'b1; Mem_enable512x32 = 1'b1; end
            default: begin end
          endcase
        end
        default: begin end  // HALT: everything low, run already low
      endcase
    end else begin
      run = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// -----------------------------------------------------------------------------
// tb_control_sequencer
//
// Table of instruction vectors, each with its hand-written per-step control
// word. Expected words are pushed to a scoreboard queue when an instruction is
// launched and popped/compared against the DUT on every falling Clock edge.
// Reset, halt and reset-mid-instruction are driven as short explicit sequences.
// -----------------------------------------------------------------------------
module tb_control_sequencer;

  // Bit positions of the packed control word compared every cycle.
  localparam logic [33:0] B1      = 34'd1;
  localparam logic [33:0] HIOUT   = B1 << 5;
  localparam logic [33:0] LOOUT   = B1 << 6;
  localparam logic [33:0] ZHIOUT  = B1 << 7;
  localparam logic [33:0] ZLOOUT  = B1 << 8;
  localparam logic [33:0] PCOUT   = B1 << 9;
  localparam logic [33:0] MDROUT  = B1 << 10;
  localparam logic [33:0] INPOUT  = B1 << 11;
  localparam logic [33:0] COUT    = B1 << 12;
  localparam logic [33:0] MARIN   = B1 << 13;
  localparam logic [33:0] ZIN     = B1 << 14;
  localparam logic [33:0] PCIN    = B1 << 15;
  localparam logic [33:0] MDRIN   = B1 << 16;
  localparam logic [33:0] IRIN    = B1 << 17;
  localparam logic [33:0] YIN     = B1 << 18;
  localparam logic [33:0] HIIN    = B1 << 19;
  localparam logic [33:0] LOIN    = B1 << 20;
  localparam logic [33:0] CONIN   = B1 << 21;
  localparam logic [33:0] OUTPIN  = B1 << 22;
  localparam logic [33:0] GRA     = B1 << 23;
  localparam logic [33:0] GRB     = B1 << 24;
  localparam logic [33:0] GRC     = B1 << 25;
  localparam logic [33:0] RIN     = B1 << 26;
  localparam logic [33:0] ROUT    = B1 << 27;
  localparam logic [33:0] BAOUT   = B1 << 28;
  localparam logic [33:0] INCPC   = B1 << 29;
  localparam logic [33:0] MRD     = B1 << 30;
  localparam logic [33:0] MWR     = B1 << 31;
  localparam logic [33:0] MEN     = B1 << 32;
  localparam logic [33:0] RUN     = B1 << 33;
  localparam logic [33:0] NONE    = 34'd0;

  localparam logic [33:0] F0 = RUN | PCOUT | INCPC | MARIN | ZIN;
  localparam logic [33:0] F1 = RUN | ZLOOUT | PCIN | MDRIN | MRD | MEN;
  localparam logic [33:0] F2 = RUN | MDROUT | IRIN;

  typedef struct {
    logic [31:0]       ir;
    logic              con;
    int                n;
    logic [7:0][33:0]  ex;
  } vec_t;

  typedef struct {
    logic [33:0] word;
    int          id;
    int          step;
  } sb_t;

  logic        Clock;
  logic        clear;
  logic [31:0] IR;
  logic        con_ff_bit;
  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin, outport_in;
  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic [4:0] opcode;
  logic IncPC, Mem_Read, Mem_Write, Mem_enable512x32, run;
  logic [33:0] dut_word;

  vec_t vecs[$];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  control_sequencer #(.DATA_WIDTH(32), .OP_ADD(5'b00011)) dut (
    .Clock(Clock), .clear(clear), .IR(IR), .con_ff_bit(con_ff_bit),
    .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
    .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .outport_in(outport_in),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .opcode(opcode), .IncPC(IncPC), .Mem_Read(Mem_Read), .Mem_Write(Mem_Write),
    .Mem_enable512x32(Mem_enable512x32), .run(run)
  );

  assign dut_word = {run, Mem_enable512x32, Mem_Write, Mem_Read, IncPC, BAout,
                     Rout, Rin, Grc, Grb, Gra, outport_in, CONin, LOin, HIin,
                     Yin, IRin, MDRin, PCin, Zin, MARin, Cout, Inport_out,
                     MDRout, PCout, Zlo_out, Zhi_out, LOout, HIout, opcode};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic logic [33:0] op(input logic [4:0] o);
    return {29'd0, o};
  endfunction

  task automatic add_vec(input logic [31:0] ir, input logic con, input int n,
                         input logic [33:0] e3, input logic [33:0] e4,
                         input logic [33:0] e5, input logic [33:0] e6,
                         input logic [33:0] e7);
    vec_t v;
    v.ir = ir; v.con = con; v.n = n;
    v.ex[0] = F0; v.ex[1] = F1; v.ex[2] = F2;
    v.ex[3] = e3; v.ex[4] = e4; v.ex[5] = e5; v.ex[6] = e6; v.ex[7] = e7;
    vecs.push_back(v);
  endtask

  task automatic push_exp(input logic [33:0] w, input int id, input int step);
    sb_q.push_back('{word: w, id: id, step: step});
  endtask

  // Each cycle: compare at the falling edge, then move just past the next
  // rising edge where new stimulus may be applied.
  task automatic run_cycles(input int n, input string name);
    sb_t it;
    for (int c = 0; c < n; c++) begin
      @(negedge Clock);
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s scoreboard empty actual=%h", name, dut_word);
      end else begin
        it = sb_q.pop_front();
        if (dut_word !== it.word) begin
          n_fail++;
          $display("FAIL %s id=%0d step=%0d actual=%h required=%h",
                   name, it.id, it.step, dut_word, it.word);
        end
      end
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic push_nop(input int id);
    push_exp(F0, id, 0); push_exp(F1, id, 1);
    push_exp(F2, id, 2); push_exp(RUN, id, 3);
  endtask

  initial begin
    // add r3,r3,r6
    add_vec(32'h19918000, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|op(5'b00011)|ZIN,
            RUN|ZLOOUT|GRA|RIN, NONE, NONE);
    // shl
    add_vec(32'h58000000, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|GRC|ROUT|op(5'b01011)|ZIN,
            RUN|ZLOOUT|GRA|RIN, NONE, NONE);
    // addi
    add_vec(32'h60000000, 1'b0, 6, RUN|GRB|ROUT|YIN, RUN|COUT|op(5'b01100)|ZIN,
            RUN|ZLOOUT|GRA|RIN, NONE, NONE);
    // neg
    add_vec(32'h88000000, 1'b0, 5, RUN|GRB|ROUT|op(5'b10001)|ZIN,
            RUN|ZLOOUT|GRA|RIN, NONE, NONE, NONE);
    // mul
    add_vec(32'h80000000, 1'b0, 7, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|op(5'b10000)|ZIN,
            RUN|ZLOOUT|LOIN, RUN|ZHIOUT|HIIN, NONE);
    // div
    add_vec(32'h78000000, 1'b0, 7, RUN|GRA|ROUT|YIN, RUN|GRB|ROUT|op(5'b01111)|ZIN,
            RUN|ZLOOUT|LOIN, RUN|ZHIOUT|HIIN, NONE);
    // ldi
    add_vec(32'h08000000, 1'b0, 6, RUN|GRB|BAOUT|YIN, RUN|COUT|op(5'b00011)|ZIN,
            RUN|ZLOOUT|GRA|RIN, NONE, NONE);
    // ld
    add_vec(32'h00000000, 1'b0, 8, RUN|GRB|BAOUT|YIN, RUN|COUT|op(5'b00011)|ZIN,
            RUN|ZLOOUT|MARIN, RUN|MRD|MEN|MDRIN, RUN|MDROUT|GRA|RIN);
    // st
    add_vec(32'h10000000, 1'b0, 8, RUN|GRB|BAOUT|YIN, RUN|COUT|op(5'b00011)|ZIN,
            RUN|ZLOOUT|MARIN, RUN|GRA|ROUT|MDRIN, RUN|MWR|MEN);
    // br taken
    add_vec(32'h98000000, 1'b1, 7, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN,
            RUN|COUT|op(5'b00011)|ZIN, RUN|ZLOOUT|PCIN, NONE);
    // br not taken
    add_vec(32'h98000000, 1'b0, 7, RUN|GRA|ROUT|CONIN, RUN|PCOUT|YIN,
            RUN|COUT|op(5'b00011)|ZIN, RUN, NONE);
    // jr
    add_vec(32'hA3000000, 1'b0, 4, RUN|GRA|ROUT|PCIN, NONE, NONE, NONE, NONE);
    // jal
    add_vec(32'hABF80000, 1'b0, 5, RUN|GRB|RIN|PCOUT, RUN|GRA|ROUT|PCIN,
            NONE, NONE, NONE);
    // in / out
    add_vec(32'hB0000000, 1'b0, 4, RUN|GRA|RIN|INPOUT, NONE, NONE, NONE, NONE);
    add_vec(32'hB8000000, 1'b0, 4, RUN|GRA|ROUT|OUTPIN, NONE, NONE, NONE, NONE);
    // mfhi / mflo
    add_vec(32'hC0000000, 1'b0, 4, RUN|HIOUT|GRA|RIN, NONE, NONE, NONE, NONE);
    add_vec(32'hC8000000, 1'b0, 4, RUN|LOOUT|GRA|RIN, NONE, NONE, NONE, NONE);
    // nop and undefined opcodes
    add_vec(32'hD0000000, 1'b0, 4, RUN, NONE, NONE, NONE, NONE);
    add_vec(32'hF8000000, 1'b0, 4, RUN, NONE, NONE, NONE, NONE);
    add_vec(32'hE0000000, 1'b1, 4, RUN, NONE, NONE, NONE, NONE);

    // Reset state: everything low, including run.
    clear = 1'b0; IR = 32'h19918000; con_ff_bit = 1'b0;
    push_exp(NONE, 100, 0); push_exp(NONE, 100, 1);
    run_cycles(2, "reset");
    clear = 1'b1;

    // Table-driven instruction sequences.
    for (int i = 0; i < vecs.size(); i++) begin
      IR = vecs[i].ir;
      con_ff_bit = vecs[i].con;
      for (int s = 0; s < vecs[i].n; s++) push_exp(vecs[i].ex[s], i, s);
      run_cycles(vecs[i].n, "vec");
    end

    // Reset asserted just after entering T4 of add: outputs drop within the
    // cycle, and after release a fresh fetch starts at T0.
    IR = 32'h19918000; con_ff_bit = 1'b0;
    push_exp(F0, 200, 0); push_exp(F1, 200, 1); push_exp(F2, 200, 2);
    push_exp(RUN|GRB|ROUT|YIN, 200, 3);
    run_cycles(4, "add_pre_reset");
    clear = 1'b0;
    push_exp(NONE, 201, 0); push_exp(NONE, 201, 1);
    run_cycles(2, "mid_reset");
    clear = 1'b1;
    IR = 32'hD0000000;
    push_nop(202);
    run_cycles(4, "post_reset_fetch");

    // Halt: fetch plus an empty T3, then 20 idle cycles with run low even
    // though IR changes underneath, until reset.
    IR = 32'hD8000000;
    push_exp(F0, 300, 0); push_exp(F1, 300, 1); push_exp(F2, 300, 2);
    push_exp(RUN, 300, 3);
    run_cycles(4, "halt_entry");
    IR = 32'h19918000;
    for (int k = 0; k < 20; k++) push_exp(NONE, 301, k);
    run_cycles(20, "halted");
    clear = 1'b0;
    push_exp(NONE, 302, 0);
    run_cycles(1, "halt_reset");
    clear = 1'b1;
    IR = 32'hD0000000;
    push_nop(303);
    run_cycles(4, "halt_restart");

    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
